// File: rtl/tl_sensor_gen.sv
// tl_sensor_gen: per-lane vehicle queues that drive the traffic sensors from detector pulses and light state
//   clk    : system clock, rising edge
//   reset  : asynchronous active-high reset
//   car_in : detector levels, bit0 A straight, bit1 A left, bit2 B straight, bit3 B left
//   green  : per-lane green indicators, same bit order as car_in
//   ta/tal/tb/tbl : lane queue non-empty (A straight, A left, B straight, B left)
//   q_cnt  : packed queue counts, lane i at [i*CNT_W +: CNT_W]
//   ovf    : sticky per-lane overflow flags
module tl_sensor_gen #(
    parameter int CNT_W   = 3,
    parameter int DEP_CYC = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         car_in,
    input  logic [3:0]         green,
    output logic               ta,
    output logic               tal,
    output logic               tb,
    output logic               tbl,
    output logic [4*CNT_W-1:0] q_cnt,
    output logic [3:0]         ovf
);
    localparam int              TW   = (DEP_CYC > 1) ? $clog2(DEP_CYC) : 1;
    localparam logic [TW-1:0]   LAST = TW'(DEP_CYC - 1);
    localparam logic [CNT_W-1:0] MAX = '1;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic             car_d;
        logic             of;
        logic [CNT_W-1:0] cnt;
        logic [TW-1:0]    tmr;
        logic             arr;
        logic             run;
        logic             dep;
        always_comb begin
            arr = car_in[i] & ~car_d;
            run = green[i] & (cnt != '0);
            dep = run & (tmr == LAST);
        end
        // timer only runs while the lane can actually drain; any pause discards the partial interval
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                car_d <= 1'b0;
                of    <= 1'b0;
                cnt   <= '0;
                tmr   <= '0;
            end else begin
                car_d <= car_in[i];
                tmr   <= (run && !dep) ? tmr + 1'b1 : '0;
                if (arr && !dep) begin
                    if (cnt != MAX) cnt <= cnt + 1'b1;
                    else of <= 1'b1;
                end else if (dep && !arr) begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
        assign q_cnt[i*CNT_W +: CNT_W] = cnt;
        assign ovf[i] = of;
    end

    assign ta  = |q_cnt[0*CNT_W +: CNT_W];
    assign tal = |q_cnt[1*CNT_W +: CNT_W];
    assign tb  = |q_cnt[2*CNT_W +: CNT_W];
    assign tbl = |q_cnt[3*CNT_W +: CNT_W];
endmodule
